// File: rtl/pmod_pkg.sv
// rtl/pmod_pkg.sv - shared state encodings and timing defaults for PMOD button debouncing
package pmod_pkg;

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_WAIT_PRESS   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_WAIT_RELEASE = 2'd3
  } btn_state_e;

  localparam int CLK_HZ      = 12000000;
  localparam int DEBOUNCE_MS = 10;

  // 10 ms at 12 MHz = 120000 cycles
  localparam int DEFAULT_DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one button: two-flop synchroniser, debounce FSM with counter,
// registered level and one-cycle press/release pulses.
module debounce_channel
  import pmod_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_n,
  output logic level,
  output logic press,
  output logic rel
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_1;
  logic             sync_2;
  logic             p;
  btn_state_e       state;
  logic [CNT_W-1:0] cnt;

  assign p = ~sync_2;

  // Level and pulses are set on the same edge as the state change, so they stay registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
      state  <= ST_RELEASED;
      cnt    <= '0;
      level  <= 1'b0;
      press  <= 1'b0;
      rel    <= 1'b0;
    end else begin
      sync_1 <= pin_n;
      sync_2 <= sync_1;
      press  <= 1'b0;
      rel    <= 1'b0;
      case (state)
        ST_RELEASED: begin
          if (p) begin
            state <= ST_WAIT_PRESS;
            cnt   <= '0;
          end
        end
        ST_WAIT_PRESS: begin
          if (!p) begin
            state <= ST_RELEASED;
          end else if (cnt == CNT_LAST) begin
            state <= ST_PRESSED;
            level <= 1'b1;
            press <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_PRESSED: begin
          if (!p) begin
            state <= ST_WAIT_RELEASE;
            cnt   <= '0;
          end
        end
        ST_WAIT_RELEASE: begin
          if (p) begin
            state <= ST_PRESSED;
          end else if (cnt == CNT_LAST) begin
            state <= ST_RELEASED;
            level <= 1'b0;
            rel   <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= ST_RELEASED;
      endcase
    end
  end

endmodule

// File: rtl/pmod_debounce.sv
// rtl/pmod_debounce.sv - debounces NUM_BTN active-low PMOD buttons into active-high
// levels with one-cycle press/release pulses.
module pmod_debounce
  import pmod_pkg::*;
#(
  parameter int NUM_BTN         = 3,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] pmod,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk  (clk),
      .rst  (rst),
      .pin_n(pmod[i]),
      .level(btn_level[i]),
      .press(btn_press[i]),
      .rel  (btn_release[i])
    );
  end

endmodule

// File: tb/tb_pmod_debounce.sv
// tb/tb_pmod_debounce.sv - self-checking bench for pmod_debounce with a sliding-window
// reference model (a change is accepted once D+1 consecutive synced samples disagree).
module tb_pmod_debounce;

  localparam int NB = 3;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] pmod = '1;
  logic [NB-1:0] btn_level, btn_press, btn_release;

  int n_cmp = 0;
  int n_bad = 0;

  logic [NB-1:0] m_level, m_press, m_rel, m_d1, m_d2;
  logic [D:0]    win [NB];

  pmod_debounce #(.NUM_BTN(NB), .DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .pmod       (pmod),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    logic p;
    for (int c = 0; c < NB; c++) begin
      if (rst) begin
        m_d1[c] = 1'b1; m_d2[c] = 1'b1; win[c] = '0;
        m_level[c] = 1'b0; m_press[c] = 1'b0; m_rel[c] = 1'b0;
      end else begin
        p = ~m_d2[c];
        m_d2[c] = m_d1[c];
        m_d1[c] = pmod[c];
        win[c] = {win[c][D-1:0], p};
        m_press[c] = 1'b0;
        m_rel[c]   = 1'b0;
        if (win[c] == {(D+1){~m_level[c]}}) begin
          m_level[c] = ~m_level[c];
          m_press[c] = m_level[c];
          m_rel[c]   = ~m_level[c];
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; pmod = '1;
    tick(); tick();
    n_cmp++;
    if ({btn_level, btn_press, btn_release} !== 9'b0) begin
      n_bad++; $display("FAIL reset_outputs got %b exp 0", {btn_level, btn_press, btn_release});
    end
    rst = 1'b0;
    for (int t = 0; t < 50; t++) begin
      tick();
      n_cmp++;
      if ({btn_level, btn_press, btn_release} !== 9'b0) begin
        n_bad++; $display("FAIL idle_outputs cycle %0d got %b exp 0", t, {btn_level, btn_press, btn_release});
      end
    end
  endtask

  task automatic test_clean_press();
    int lat = -1; int npress = 0;
    pmod[0] = 1'b0;
    for (int t = 0; t < 12; t++) begin
      tick();
      n_cmp++;
      if ({btn_level, btn_press, btn_release} !== {m_level, m_press, m_rel}) begin
        n_bad++; $display("FAIL clean_model t=%0d got %b exp %b", t, {btn_level, btn_press, btn_release}, {m_level, m_press, m_rel});
      end
      if (lat < 0 && btn_level[0]) lat = t;
      if (btn_press[0]) npress++;
    end
    n_cmp++;
    if (lat != D + 2) begin n_bad++; $display("FAIL clean_latency got %0d exp %0d", lat, D + 2); end
    n_cmp++;
    if (npress != 1) begin n_bad++; $display("FAIL clean_press_count got %0d exp 1", npress); end
    n_cmp++;
    if (btn_level[2:1] !== 2'b00) begin n_bad++; $display("FAIL clean_other_channels got %b exp 00", btn_level[2:1]); end
  endtask

  task automatic test_bounce();
    int pat_v [4] = '{0, 1, 0, 1};
    int pat_n [4] = '{3, 1, 2, 1};
    int t = 0; int t_rise = -1; int npress = 0; int j;
    for (int s = 0; s < 4; s++) begin
      pmod[1] = pat_v[s][0];
      for (int k = 0; k < pat_n[s]; k++) begin
        tick();
        n_cmp++;
        if ({btn_level, btn_press, btn_release} !== {m_level, m_press, m_rel}) begin
          n_bad++; $display("FAIL bounce_model t=%0d got %b exp %b", t, {btn_level, btn_press, btn_release}, {m_level, m_press, m_rel});
        end
        if (t_rise < 0 && btn_level[1]) t_rise = t;
        if (btn_press[1]) npress++;
        t++;
      end
    end
    j = t;
    pmod[1] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      n_cmp++;
      if ({btn_level, btn_press, btn_release} !== {m_level, m_press, m_rel}) begin
        n_bad++; $display("FAIL bounce_model t=%0d got %b exp %b", t, {btn_level, btn_press, btn_release}, {m_level, m_press, m_rel});
      end
      if (t_rise < 0 && btn_level[1]) t_rise = t;
      if (btn_press[1]) npress++;
      t++;
    end
    n_cmp++;
    if (t_rise != j + D + 2) begin n_bad++; $display("FAIL bounce_latency got %0d exp %0d", t_rise, j + D + 2); end
    n_cmp++;
    if (npress != 1) begin n_bad++; $display("FAIL bounce_press_count got %0d exp 1", npress); end
  endtask

  task automatic test_release();
    int t_fall = -1; int nrel = 0; int ndrop = 0;
    pmod[0] = 1'b1;
    tick(); tick();
    pmod[0] = 1'b0;
    for (int t = 0; t < 10; t++) begin
      tick();
      n_cmp++;
      if ({btn_level, btn_press, btn_release} !== {m_level, m_press, m_rel}) begin
        n_bad++; $display("FAIL glitch_model t=%0d got %b exp %b", t, {btn_level, btn_press, btn_release}, {m_level, m_press, m_rel});
      end
      if (!btn_level[0] || btn_release[0]) ndrop++;
    end
    n_cmp++;
    if (ndrop != 0) begin n_bad++; $display("FAIL glitch_no_change got %0d exp 0", ndrop); end
    pmod[0] = 1'b1;
    for (int t = 0; t < 12; t++) begin
      tick();
      n_cmp++;
      if ({btn_level, btn_press, btn_release} !== {m_level, m_press, m_rel}) begin
        n_bad++; $display("FAIL release_model t=%0d got %b exp %b", t, {btn_level, btn_press, btn_release}, {m_level, m_press, m_rel});
      end
      if (t_fall < 0 && !btn_level[0]) t_fall = t;
      if (btn_release[0]) nrel++;
    end
    n_cmp++;
    if (t_fall != D + 2) begin n_bad++; $display("FAIL release_latency got %0d exp %0d", t_fall, D + 2); end
    n_cmp++;
    if (nrel != 1) begin n_bad++; $display("FAIL release_count got %0d exp 1", nrel); end
  endtask

  task automatic test_simultaneous();
    int t_all = -1; int nall = 0;
    pmod = '1;
    for (int t = 0; t < 12; t++) tick();
    n_cmp++;
    if (btn_level !== 3'b000) begin n_bad++; $display("FAIL simul_idle got %b exp 000", btn_level); end
    pmod = '0;
    for (int t = 0; t < 12; t++) begin
      tick();
      n_cmp++;
      if ({btn_level, btn_press, btn_release} !== {m_level, m_press, m_rel}) begin
        n_bad++; $display("FAIL simul_model t=%0d got %b exp %b", t, {btn_level, btn_press, btn_release}, {m_level, m_press, m_rel});
      end
      if (btn_press == 3'b111) begin
        nall++;
        if (t_all < 0) t_all = t;
      end
    end
    n_cmp++;
    if (t_all != D + 2) begin n_bad++; $display("FAIL simul_latency got %0d exp %0d", t_all, D + 2); end
    n_cmp++;
    if (nall != 1) begin n_bad++; $display("FAIL simul_press_count got %0d exp 1", nall); end
  endtask

  task automatic test_reset_mid();
    int t_p = -1; int nrel = 0;
    n_cmp++;
    if (btn_level[2] !== 1'b1) begin n_bad++; $display("FAIL rstmid_precond got %b exp 1", btn_level[2]); end
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({btn_level, btn_press, btn_release} !== 9'b0) begin
      n_bad++; $display("FAIL rstmid_outputs got %b exp 0", {btn_level, btn_press, btn_release});
    end
    rst = 1'b0;
    for (int t = 0; t < 12; t++) begin
      tick();
      n_cmp++;
      if ({btn_level, btn_press, btn_release} !== {m_level, m_press, m_rel}) begin
        n_bad++; $display("FAIL rstmid_model t=%0d got %b exp %b", t, {btn_level, btn_press, btn_release}, {m_level, m_press, m_rel});
      end
      if (t_p < 0 && btn_press[2]) t_p = t;
      if (btn_release != 3'b000) nrel++;
    end
    n_cmp++;
    if (t_p != D + 2) begin n_bad++; $display("FAIL rstmid_press_latency got %0d exp %0d", t_p, D + 2); end
    n_cmp++;
    if (nrel != 0) begin n_bad++; $display("FAIL rstmid_no_release got %0d exp 0", nrel); end
  endtask

  task automatic test_random();
    int hold [NB];
    for (int c = 0; c < NB; c++) hold[c] = 1;
    for (int t = 0; t < 3000; t++) begin
      for (int c = 0; c < NB; c++) begin
        hold[c]--;
        if (hold[c] == 0) begin
          pmod[c] = ~pmod[c];
          hold[c] = $urandom_range(1, 2 * D + 3);
        end
      end
      if ($urandom_range(0, 999) == 0) rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++;
      if ({btn_level, btn_press, btn_release} !== {m_level, m_press, m_rel}) begin
        n_bad++; $display("FAIL random_model t=%0d got %b exp %b", t, {btn_level, btn_press, btn_release}, {m_level, m_press, m_rel});
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
